// File: rtl/tt_pin_loopback_bist.sv
// ---------------------------------------------------------------------------
// tt_pin_loopback_bist
//
// Built-in self-test for the bidirectional pin bank of a TinyTapeout-style
// user project. A run drives NUM_PATTERNS generated patterns onto uio_out
// (with uio_oe high), and compares the externally looped-back uio_in against
// a copy of each pattern delayed by LAT cycles. Mismatches are counted and
// reported on uo_out together with busy/done/pass status.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   ena        design enable; low aborts a run and blocks start
//   ui_in      [0] start (level), [1] abort, [2] mode (0 LFSR, 1 walking-one),
//              [7:3] seed
//   uo_out     [0] busy, [1] done, [2] pass, [3] err_sticky,
//              [7:4] err_cnt (saturating at 15)
//   uio_in     looped-back pin value (IO_W bits)
//   uio_out    driven pattern (IO_W bits)
//   uio_oe     output enables, 1 = drive (IO_W bits)
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
// ---------------------------------------------------------------------------
module tt_pin_loopback_bist #(
   parameter int IO_W         = 8,
   parameter int NUM_PATTERNS = 256,
   parameter int LAT          = 2,
   parameter bit MODE_DEF     = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic [7:0]      ui_in,
   output logic [7:0]      uo_out,
   input  logic [IO_W-1:0] uio_in,
   output logic [IO_W-1:0] uio_out,
   output logic [IO_W-1:0] uio_oe,
   output logic [1:0]      dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // The delay line always has at least one stage so the array is legal for
   // LAT = 0; in that case it is bypassed and the compare uses the live pattern.
   localparam int          DL_N     = (LAT == 0) ? 1 : LAT;
   localparam int          TAP      = (LAT == 0) ? 0 : LAT - 1;
   localparam logic [15:0] LAST_IDX = 16'(NUM_PATTERNS - 1);

   // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form.
   function automatic logic [15:0] lfsr_next(input logic [15:0] x);
      return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
   endfunction

   // Rotate left by one; also correct for IO_W = 1.
   function automatic logic [IO_W-1:0] rotl(input logic [IO_W-1:0] x);
      return (x << 1) | (x >> (IO_W - 1));
   endfunction

   state_e            state_q, state_d;
   logic [IO_W-1:0]   uio_out_q, uio_out_d;
   logic [IO_W-1:0]   uio_oe_q, uio_oe_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              sticky_q, sticky_d;
   logic [3:0]        err_cnt_q, err_cnt_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [IO_W-1:0]   walk_q, walk_d;
   logic              mode_q, mode_d;
   logic [15:0]       pat_cnt_q, pat_cnt_d;
   logic [2:0]        drain_q, drain_d;
   // Each stage: {valid, expected pattern}.
   logic [IO_W:0]     dl_q [DL_N];
   logic [IO_W:0]     dl_d [DL_N];

   logic              start;
   logic              abort;
   logic              mode_sel;
   logic [15:0]       seed;
   logic [IO_W:0]     tap;
   logic              mismatch;
   logic [3:0]        err_cnt_upd;
   logic              sticky_upd;
   logic              finish;

   always_comb begin
      start    = ui_in[0];
      abort    = ui_in[1] | ~ena;
      // The pin strap flips the built-in default mode.
      mode_sel = MODE_DEF ^ ui_in[2];
      // Low 11 bits are never touched, so the seed can never be zero.
      seed     = 16'hACE1 ^ {ui_in[7:3], 11'b0};

      tap         = (LAT == 0) ? {state_q == S_RUN, uio_out_q} : dl_q[TAP];
      mismatch    = tap[IO_W] & (|(tap[IO_W-1:0] ^ uio_in));
      err_cnt_upd = (mismatch && (err_cnt_q != 4'hF)) ? err_cnt_q + 4'd1 : err_cnt_q;
      sticky_upd  = sticky_q | mismatch;

      state_d   = state_q;
      uio_out_d = uio_out_q;
      uio_oe_d  = uio_oe_q;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;
      sticky_d  = sticky_upd;
      err_cnt_d = err_cnt_upd;
      lfsr_d    = lfsr_q;
      walk_d    = walk_q;
      mode_d    = mode_q;
      pat_cnt_d = pat_cnt_q;
      drain_d   = drain_q;
      finish    = 1'b0;

      dl_d[0] = {state_q == S_RUN, uio_out_q};
      for (int i = 1; i < DL_N; i++) begin
         dl_d[i] = dl_q[i-1];
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_RUN;
               mode_d    = mode_sel;
               // Both generators are loaded with pattern 1 ready as "next".
               lfsr_d    = lfsr_next(seed);
               walk_d    = rotl(IO_W'(1));
               uio_out_d = mode_sel ? IO_W'(1) : seed[IO_W-1:0];
               uio_oe_d  = '1;
               pat_cnt_d = '0;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               sticky_d  = 1'b0;
               err_cnt_d = '0;
            end
         end
         S_RUN: begin
            if (pat_cnt_q == LAST_IDX) begin
               if (LAT == 0) begin
                  finish = 1'b1;
               end else begin
                  state_d = S_DRAIN;
                  drain_d = 3'(LAT - 1);
               end
            end else begin
               pat_cnt_d = pat_cnt_q + 16'd1;
               uio_out_d = mode_q ? walk_q : lfsr_q[IO_W-1:0];
               lfsr_d    = lfsr_next(lfsr_q);
               walk_d    = rotl(walk_q);
            end
         end
         S_DRAIN: begin
            if (drain_q == 3'd0) begin
               finish = 1'b1;
            end else begin
               drain_d = drain_q - 3'd1;
            end
         end
         S_DONE: begin
            if (!start) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // The last compare lands on this same edge, so pass uses the updated count.
      if (finish) begin
         state_d   = S_DONE;
         busy_d    = 1'b0;
         done_d    = 1'b1;
         pass_d    = (err_cnt_upd == 4'd0);
         uio_oe_d  = '0;
         uio_out_d = '0;
      end

      if (abort) begin
         state_d   = S_IDLE;
         uio_out_d = '0;
         uio_oe_d  = '0;
         busy_d    = 1'b0;
         done_d    = 1'b0;
         pass_d    = 1'b0;
         sticky_d  = 1'b0;
         err_cnt_d = '0;
         for (int i = 0; i < DL_N; i++) begin
            dl_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         uio_out_q <= '0;
         uio_oe_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         sticky_q  <= 1'b0;
         err_cnt_q <= '0;
         lfsr_q    <= 16'hACE1;
         walk_q    <= IO_W'(1);
         mode_q    <= 1'b0;
         pat_cnt_q <= '0;
         drain_q   <= '0;
         for (int i = 0; i < DL_N; i++) begin
            dl_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         uio_out_q <= uio_out_d;
         uio_oe_q  <= uio_oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         sticky_q  <= sticky_d;
         err_cnt_q <= err_cnt_d;
         lfsr_q    <= lfsr_d;
         walk_q    <= walk_d;
         mode_q    <= mode_d;
         pat_cnt_q <= pat_cnt_d;
         drain_q   <= drain_d;
         for (int i = 0; i < DL_N; i++) begin
            dl_q[i] <= dl_d[i];
         end
      end
   end

   assign uio_out   = uio_out_q;
   assign uio_oe    = uio_oe_q;
   assign uo_out    = {err_cnt_q, sticky_q, pass_q, done_q, busy_q};
   assign dbg_state = state_q;

endmodule

// File: tb/tb_tt_pin_loopback_bist.sv
// ---------------------------------------------------------------------------
// tb_tt_pin_loopback_bist
//
// Bench for tt_pin_loopback_bist with the default parameters (IO_W 8,
// 256 patterns, LAT 2). An external loopback delays uio_out by two cycles
// into uio_in and can corrupt chosen pattern indices. Drivers queue the
// expected pattern stream and final status; a monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_tt_pin_loopback_bist;

   localparam int IO_W = 8;
   localparam int NUM  = 256;
   localparam int LAT  = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            ena;
   logic [7:0]      ui_in;
   logic [7:0]      uo_out;
   logic [IO_W-1:0] uio_in;
   logic [IO_W-1:0] uio_out;
   logic [IO_W-1:0] uio_oe;
   logic [1:0]      dbg_state;

   always #5 clk = ~clk;

   tt_pin_loopback_bist #(
      .IO_W(IO_W), .NUM_PATTERNS(NUM), .LAT(LAT), .MODE_DEF(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
      .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe), .dbg_state(dbg_state)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] pat_q[$];
   logic [7:0] st_q[$];
   bit         pat_chk_en = 1'b0;

   // Loopback model with fault injection on run-cycle indices f_lo..f_hi.
   int         f_lo   = 1000;
   int         f_hi   = 0;
   logic [7:0] f_mask = 8'h00;
   logic [7:0] lb_d1  = 8'h00;
   logic [7:0] lb_d2  = 8'h00;
   int         run_cyc = 0;

   assign uio_in = lb_d2;

   always @(posedge clk) begin
      lb_d1   <= uio_out ^ (((run_cyc >= f_lo) && (run_cyc <= f_hi)) ? f_mask : 8'h00);
      lb_d2   <= lb_d1;
      run_cyc <= uo_out[0] ? run_cyc + 1 : 0;
   end

   function automatic logic [15:0] lfsr_step(input logic [15:0] x);
      return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%02h required=%02h", name, act, exp);
      end
   endtask

   // Monitor: per-pattern compare during RUN, status compare on done rising.
   bit prev_busy = 1'b0;
   bit prev_done = 1'b0;
   int mon_cyc   = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_busy = 1'b0;
         prev_done = 1'b0;
      end else begin
         if (uo_out[0]) begin
            if (!prev_busy) mon_cyc = 0;
            if (pat_chk_en && (mon_cyc < NUM)) begin
               if (pat_q.size() == 0) begin
                  check("pattern_queue_empty", 8'h01, 8'h00);
               end else begin
                  check("pattern", uio_out, pat_q.pop_front());
                  check("oe_run", uio_oe, 8'hFF);
               end
            end
            mon_cyc++;
         end
         if (uo_out[1] && !prev_done) begin
            if (st_q.size() == 0) begin
               check("unexpected_done", uo_out, 8'h00);
            end else begin
               check("final_status", uo_out, st_q.pop_front());
               check("busy_cycles", 8'(mon_cyc - NUM), 8'(LAT));
               check("oe_done", uio_oe, 8'h00);
            end
         end
         prev_busy = uo_out[0];
         prev_done = uo_out[1];
      end
   end

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!uo_out[1] && n < 2000);
      if (!uo_out[1]) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=%02h required=done", uo_out);
      end
   endtask

   task automatic do_run(input logic mode, input logic [4:0] seed, input int lo,
                         input int hi, input logic [7:0] mask, input logic [7:0] exp_st);
      logic [15:0] l;
      l = 16'hACE1 ^ {seed, 11'b0};
      for (int k = 0; k < NUM; k++) begin
         if (mode) begin
            pat_q.push_back(8'(1 << (k % IO_W)));
         end else begin
            pat_q.push_back(l[7:0]);
            l = lfsr_step(l);
         end
      end
      st_q.push_back(exp_st);
      f_lo = lo;
      f_hi = hi;
      f_mask = mask;
      pat_chk_en = 1'b1;
      @(negedge clk);
      ui_in = {seed, mode, 1'b0, 1'b1};
      wait_done();
      @(negedge clk);
      pat_chk_en = 1'b0;
      check("patterns_left", 8'(pat_q.size()), 8'h00);
      check("status_left", 8'(st_q.size()), 8'h00);
      pat_q.delete();
      st_q.delete();
      f_lo = 1000;
      f_hi = 0;
   endtask

   initial begin
      logic [15:0] l;
      int n;

      // Reset with start held high.
      rst_n = 1'b0;
      ena   = 1'b1;
      ui_in = 8'h01;
      repeat (3) @(negedge clk);
      check("reset_uo_out", uo_out, 8'h00);
      check("reset_uio_oe", uio_oe, 8'h00);
      check("reset_uio_out", uio_out, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);
      check("busy_after_reset", {7'b0, uo_out[0]}, 8'h01);
      check("first_pattern", uio_out, 8'hE1);
      check("first_oe", uio_oe, 8'hFF);
      ui_in = 8'h02;
      @(negedge clk);
      check("abort_early_uo", uo_out, 8'h00);
      check("abort_early_oe", uio_oe, 8'h00);
      ui_in = 8'h00;
      @(negedge clk);

      // Clean LFSR run, seed 0.
      do_run(1'b0, 5'h00, 1000, 0, 8'h00, 8'h06);

      // start still high in DONE: no retrigger.
      repeat (20) @(negedge clk);
      check("held_start_uo", uo_out, 8'h06);
      check("held_start_state", 8'(dbg_state), 8'h03);
      ui_in[0] = 1'b0;
      @(negedge clk);
      check("idle_after_drop", 8'(dbg_state), 8'h00);

      // Five faults on bit 3, patterns 10..14.
      do_run(1'b0, 5'h00, 10, 14, 8'h08, 8'h5A);
      ui_in[0] = 1'b0;
      @(negedge clk);

      // Saturation: 20 fully inverted patterns.
      do_run(1'b0, 5'h00, 50, 69, 8'hFF, 8'hFA);
      ui_in[0] = 1'b0;
      @(negedge clk);

      // Walking-one.
      do_run(1'b1, 5'h00, 1000, 0, 8'h00, 8'h06);
      ui_in[0] = 1'b0;
      @(negedge clk);

      // Abort during pattern 100 with start held (abort wins).
      ui_in = 8'h01;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(uo_out[0] && run_cyc == 100) && n < 500);
      l = 16'hACE1;
      for (int k = 0; k < 100; k++) l = lfsr_step(l);
      check("pattern_100", uio_out, l[7:0]);
      ui_in = 8'h03;
      @(negedge clk);
      check("abort_uo", uo_out, 8'h00);
      check("abort_oe", uio_oe, 8'h00);
      check("abort_out", uio_out, 8'h00);
      @(negedge clk);
      check("abort_over_start", uo_out, 8'h00);
      ui_in = 8'h00;
      @(negedge clk);

      // ena low aborts.
      ui_in = 8'h01;
      repeat (5) @(negedge clk);
      check("ena_run_busy", {7'b0, uo_out[0]}, 8'h01);
      ena = 1'b0;
      @(negedge clk);
      check("ena_abort_uo", uo_out, 8'h00);
      check("ena_abort_oe", uio_oe, 8'h00);
      @(negedge clk);
      check("ena_blocks_start", uo_out, 8'h00);
      ui_in = 8'h00;
      ena = 1'b1;
      @(negedge clk);

      // Retrigger after drop, nonzero seed.
      do_run(1'b0, 5'h13, 1000, 0, 8'h00, 8'h06);
      ui_in = 8'h00;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
